// File: rtl/rom_burst_arbiter.sv
// Round-robin arbiter that shares one registered-output ROM port among NUM_REQ
// burst requesters and returns ID/LAST-tagged words under consumer backpressure.
module rom_burst_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int ADDR_WIDTH = 6,
  parameter  int DATA_WIDTH = 16,
  parameter  int LEN_WIDTH  = 6,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                            CLK,
  input  logic                            RESET_N,
  input  logic [NUM_REQ-1:0]              REQ_VALID,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    REQ_LEN,
  output logic [NUM_REQ-1:0]              REQ_READY,
  output logic [ADDR_WIDTH-1:0]           ROM_ADDRESS,
  output logic                            ROM_ENABLE,
  input  logic [DATA_WIDTH-1:0]           ROM_DATA,
  output logic                            RSP_VALID,
  input  logic                            RSP_READY,
  output logic [DATA_WIDTH-1:0]           RSP_DATA,
  output logic [ID_WIDTH-1:0]             RSP_ID,
  output logic                            RSP_LAST,
  output logic                            BUSY
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state, state_next;
  logic [ID_WIDTH-1:0]   ptr, id, winner, cand;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  cnt;
  logic                  any_req, grant, issue;

  // Scan from the highest offset down so the nearest requester after ptr wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    winner  = ptr;
    cand    = ptr;
    any_req = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
      if (REQ_VALID[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

  assign grant = (state == IDLE) && any_req;
  // A word may be issued only when the response slot is empty or draining.
  assign issue = (state == BURST) && (!RSP_VALID || RSP_READY);

  always_comb begin
    REQ_READY = '0;
    if (grant) REQ_READY[winner] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = BURST;
      BURST:   if (issue && cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state <= IDLE;
      ptr   <= ID_WIDTH'(NUM_REQ - 1);
      id    <= '0;
      addr  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        ptr  <= winner;
        id   <= winner;
        addr <= REQ_ADDR[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
        cnt  <= REQ_LEN[int'(winner)*LEN_WIDTH +: LEN_WIDTH];
      end else if (issue) begin
        addr <= addr + ADDR_WIDTH'(1);
        cnt  <= cnt - LEN_WIDTH'(1);
      end
    end
  end

  // Response tags track the ROM's one-cycle read latency.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      RSP_VALID <= 1'b0;
      RSP_ID    <= '0;
      RSP_LAST  <= 1'b0;
    end else if (issue) begin
      RSP_VALID <= 1'b1;
      RSP_ID    <= id;
      RSP_LAST  <= (cnt == '0);
    end else if (RSP_READY) begin
      RSP_VALID <= 1'b0;
    end
  end

  assign ROM_ENABLE  = issue;
  assign ROM_ADDRESS = addr;
  assign RSP_DATA    = ROM_DATA;
  assign BUSY        = (state != IDLE) || RSP_VALID;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Self-checking bench for rom_burst_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin/burst scoreboard.
module tb_rom_burst_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int ADDR_WIDTH = 6;
  localparam int DATA_WIDTH = 16;
  localparam int LEN_WIDTH  = 6;
  localparam int ID_WIDTH   = 2;
  localparam int ROM_WORDS  = 1 << ADDR_WIDTH;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic [NUM_REQ-1:0]            req_valid = '0;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr = '0;
  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len = '0;
  logic [NUM_REQ-1:0]            req_ready;
  logic [ADDR_WIDTH-1:0]         rom_address;
  logic                          rom_enable;
  logic [DATA_WIDTH-1:0]         rom_data;
  logic                          rsp_valid;
  logic                          rsp_ready = 1'b1;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic [ID_WIDTH-1:0]           rsp_id;
  logic                          rsp_last;
  logic                          busy;

  rom_burst_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH)
  ) dut (
    .CLK(clk), .RESET_N(rst_n),
    .REQ_VALID(req_valid), .REQ_ADDR(req_addr), .REQ_LEN(req_len), .REQ_READY(req_ready),
    .ROM_ADDRESS(rom_address), .ROM_ENABLE(rom_enable), .ROM_DATA(rom_data),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data),
    .RSP_ID(rsp_id), .RSP_LAST(rsp_last), .BUSY(busy)
  );

  always #5 clk = ~clk;

  // Registered-output ROM with one cycle of read latency.
  logic [DATA_WIDTH-1:0] mem [ROM_WORDS];
  always @(posedge clk) if (rom_enable) rom_data <= mem[rom_address];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [NUM_REQ-1:0] v);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // Scoreboard: expected issue addresses and responses, queued per granted burst.
  typedef struct {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } rsp_t;

  rsp_t                  exp_rsp [$];
  logic [ADDR_WIDTH-1:0] exp_addr [$];
  logic [ADDR_WIDTH-1:0] issue_log [$];
  int                    grant_log [$];
  int                    wait_cnt [NUM_REQ];
  int                    model_ptr = NUM_REQ - 1;
  int                    rsp_count = 0;
  logic [NUM_REQ-1:0]    granted_now = '0;
  logic                  prev_stall = 1'b0;
  logic [DATA_WIDTH-1:0] prev_data;
  logic [ID_WIDTH-1:0]   prev_id;
  logic                  prev_last;
  int                    mon_pend, mon_w, mon_a, mon_l;
  logic [ADDR_WIDTH-1:0] mon_ad;
  rsp_t                  mon_e;

  // Monitor samples on the falling edge: what it sees is what the next rising edge uses.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_rsp.delete();
      exp_addr.delete();
      model_ptr   = NUM_REQ - 1;
      prev_stall  = 1'b0;
      granted_now = '0;
      foreach (wait_cnt[i]) wait_cnt[i] = 0;
    end else begin
      mon_pend = exp_addr.size();
      if (exp_rsp.size() != 0) check("busy", busy, 1);
      if (prev_stall) begin
        check("stall_valid", rsp_valid, 1);
        check("stall_data", rsp_data, prev_data);
        check("stall_id", rsp_id, prev_id);
        check("stall_last", rsp_last, prev_last);
      end
      if (rsp_valid && !rsp_ready) check("stall_rom_en", rom_enable, 0);
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
      prev_id    = rsp_id;
      prev_last  = rsp_last;

      if (rom_enable) begin
        issue_log.push_back(rom_address);
        if (exp_addr.size() == 0) check("extra_issue", rom_enable, 0);
        else check("rom_addr", rom_address, exp_addr.pop_front());
      end

      if (rsp_valid && rsp_ready) begin
        rsp_count++;
        if (exp_rsp.size() == 0) check("extra_rsp", rsp_valid, 0);
        else begin
          mon_e = exp_rsp.pop_front();
          check("rsp_data", rsp_data, mon_e.data);
          check("rsp_id", rsp_id, mon_e.id);
          check("rsp_last", rsp_last, mon_e.last);
        end
      end

      granted_now = req_ready;
      if (req_ready != '0) begin
        check("grant_idle", mon_pend, 0);
        mon_w = rr_pick(model_ptr, req_valid);
        if (mon_w < 0) check("grant_no_req", req_ready, 0);
        else begin
          check("grant", req_ready, 32'(1) << mon_w);
          for (int i = 0; i < NUM_REQ; i++) begin
            if (i != mon_w && req_valid[i]) begin
              wait_cnt[i]++;
              check("starve", wait_cnt[i] <= NUM_REQ - 1, 1);
            end
          end
          wait_cnt[mon_w] = 0;
          model_ptr = mon_w;
          grant_log.push_back(mon_w);
          mon_a = int'(req_addr[mon_w*ADDR_WIDTH +: ADDR_WIDTH]);
          mon_l = int'(req_len[mon_w*LEN_WIDTH +: LEN_WIDTH]);
          for (int j = 0; j <= mon_l; j++) begin
            mon_ad     = ADDR_WIDTH'((mon_a + j) % ROM_WORDS);
            mon_e.id   = ID_WIDTH'(mon_w);
            mon_e.data = mem[mon_ad];
            mon_e.last = (j == mon_l);
            exp_addr.push_back(mon_ad);
            exp_rsp.push_back(mon_e);
          end
        end
      end
      for (int i = 0; i < NUM_REQ; i++) if (!req_valid[i]) wait_cnt[i] = 0;
    end
  end

  // Inputs change 1 time unit after the rising edge; granted requests retire here.
  task automatic step();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~granted_now;
  endtask

  task automatic set_req(input int i, input int a, input int l);
    req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(a);
    req_len[i*LEN_WIDTH +: LEN_WIDTH]    = LEN_WIDTH'(l);
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy || req_valid != '0 || exp_rsp.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_done"}, n < budget, 1);
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  function automatic int rand_len();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 0;
    if (r == 1) return (1 << LEN_WIDTH) - 1;
    return $urandom_range(0, 7);
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [ADDR_WIDTH-1:0] exp3 [4];

    foreach (mem[i]) mem[i] = DATA_WIDTH'($urandom);

    // Reset state
    repeat (2) step();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_last", rsp_last, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rom_addr", rom_address, 0);
    check("rst_rom_en", rom_enable, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Single 4-word burst: grant at N, ROM_ENABLE N+1..N+4, RSP_VALID from N+2
    set_req(0, 'h05, 3);
    @(negedge clk);
    check("t1_grant", req_ready, 4'b0001);
    for (int c = 0; c < 5; c++) begin
      step();
      @(negedge clk);
      check("t1_en", rom_enable, c < 4);
      if (c < 4) check("t1_addr", rom_address, 5 + c);
      check("t1_rsp_valid", rsp_valid, c >= 1);
    end
    wait_idle("t1", 50);

    // All requesters held with len 0: grant order 0,1,2,3,0
    do_reset();
    grant_log.delete();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, i * 8, 0);
    n = 0;
    while (grant_log.size() < 5 && n < 100) begin
      step();
      req_valid = '1;
      n++;
    end
    req_valid = '0;
    check("t2_count", grant_log.size() >= 5, 1);
    for (int k = 0; k < 5 && k < grant_log.size(); k++) check("t2_order", grant_log[k], k % NUM_REQ);
    wait_idle("t2", 100);

    // Address wrap inside a burst
    issue_log.delete();
    set_req(1, 'h3E, 3);
    wait_idle("t3", 50);
    exp3[0] = 6'h3E; exp3[1] = 6'h3F; exp3[2] = 6'h00; exp3[3] = 6'h01;
    check("t3_issues", issue_log.size(), 4);
    for (int k = 0; k < 4 && k < issue_log.size(); k++) check("t3_addr", issue_log[k], exp3[k]);

    // Backpressure at word 2 of an 8-word burst
    rsp_count = 0;
    set_req(2, 'h10, 7);
    n = 0;
    while (rsp_count < 2 && n < 50) begin
      step();
      n++;
    end
    check("t4_reach", rsp_count, 2);
    rsp_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t4_en_low", rom_enable, 0);
      check("t4_valid_hold", rsp_valid, 1);
      step();
    end
    rsp_ready = 1'b1;
    wait_idle("t4", 50);
    check("t4_words", rsp_count, 8);

    // Reset mid-burst drops everything; requester 0 wins first afterwards
    set_req(3, 'h00, 15);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_rom_en", rom_enable, 0);
    check("t5_busy", busy, 0);
    check("t5_req_ready", req_ready, 0);
    req_valid = '0;
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, $urandom_range(0, ROM_WORDS - 1), $urandom_range(0, 3));
    @(negedge clk);
    check("t5_first", req_ready, 4'b0001);
    wait_idle("t5", 200);

    // Randomized traffic with drops and backpressure
    for (int c = 0; c < 3000; c++) begin
      step();
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0)
          set_req(i, $urandom_range(0, ROM_WORDS - 1), rand_len());
        else if (req_valid[i] && $urandom_range(0, 99) == 0)
          req_valid[i] = 1'b0;
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle("t6", 2000);
    check("t6_drain_addr", exp_addr.size(), 0);
    check("t6_drain_rsp", exp_rsp.size(), 0);
    check("t6_idle_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
